// File: rtl/riscv_core_lsu_if.sv
// Request/response and data-memory port bundle for riscv_core_lsu.
// slave = LSU side, master = execute stage plus data memory.
interface riscv_core_lsu_if #(parameter int XLEN = 64);
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic            i_lsu_we;
  logic [1:0]      i_lsu_size;
  logic            i_lsu_unsigned;
  logic [XLEN-1:0] i_lsu_addr;
  logic [XLEN-1:0] i_lsu_wdata;
  logic            o_lsu_done;
  logic [XLEN-1:0] o_lsu_rdata;
  logic            o_lsu_misalign_exc;
  logic            o_lsu_mem_w_en;
  logic            o_lsu_mem_ld_extend;
  logic [1:0]      o_lsu_mem_r_w_size;
  logic [XLEN-1:0] o_lsu_mem_address;
  logic [XLEN-1:0] o_lsu_mem_wdata;
  logic [XLEN-1:0] i_lsu_mem_rdata;

  modport slave (
    input  i_lsu_valid, i_lsu_we, i_lsu_size, i_lsu_unsigned, i_lsu_addr, i_lsu_wdata,
           i_lsu_mem_rdata,
    output o_lsu_ready, o_lsu_done, o_lsu_rdata, o_lsu_misalign_exc,
           o_lsu_mem_w_en, o_lsu_mem_ld_extend, o_lsu_mem_r_w_size, o_lsu_mem_address,
           o_lsu_mem_wdata
  );

  modport master (
    output i_lsu_valid, i_lsu_we, i_lsu_size, i_lsu_unsigned, i_lsu_addr, i_lsu_wdata,
           i_lsu_mem_rdata,
    input  o_lsu_ready, o_lsu_done, o_lsu_rdata, o_lsu_misalign_exc,
           o_lsu_mem_w_en, o_lsu_mem_ld_extend, o_lsu_mem_r_w_size, o_lsu_mem_address,
           o_lsu_mem_wdata
  );
endinterface

// File: rtl/riscv_core_lsu.sv
// Load/store unit: aligned accesses go out as one access, misaligned ones as byte sequences.
// Define RISCV_LSU_MISALIGN_TRAP_EN to trap misaligned requests instead of splitting them.
module riscv_core_lsu #(
  parameter int XLEN = 64
) (
  input  logic               i_lsu_clk,
  input  logic               i_lsu_rst_n,
  riscv_core_lsu_if.slave    lsu
);

  typedef enum logic [1:0] {IDLE, ACC, BYTE, RESP} state_t;

  state_t          state_q, state_d;
  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, asm_q, asm_nxt;
  logic [2:0]      k_q;
  logic            misalign, last;

  // Low-address mask is (bytes-1); size D wraps 3'b1<<3 to 0, giving 3'b111.
  assign misalign = |(lsu.i_lsu_addr[2:0] & ((3'b001 << lsu.i_lsu_size) - 3'b001));
  assign last     = (k_q == ((3'b001 << size_q) - 3'b001));

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                              input logic [1:0] sz, input logic u);
    case (sz)
      2'd0:    extend = {{(XLEN-8){~u & v[7]}},   v[7:0]};
      2'd1:    extend = {{(XLEN-16){~u & v[15]}}, v[15:0]};
      2'd2:    extend = {{(XLEN-32){~u & v[31]}}, v[31:0]};
      default: extend = v;
    endcase
  endfunction

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{k_q, 3'b000} +: 8] = lsu.i_lsu_mem_rdata[7:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lsu.i_lsu_valid) begin
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        state_d = misalign ? RESP : ACC;
`else
        state_d = misalign ? BYTE : ACC;
`endif
      end
      ACC:     state_d = RESP;
      BYTE:    if (last) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Memory port is only live in ACC/BYTE; everything else drives zeros.
  always_comb begin
    lsu.o_lsu_mem_w_en      = 1'b0;
    lsu.o_lsu_mem_ld_extend = 1'b0;
    lsu.o_lsu_mem_r_w_size  = 2'b00;
    lsu.o_lsu_mem_address   = '0;
    lsu.o_lsu_mem_wdata     = '0;
    case (state_q)
      ACC: begin
        lsu.o_lsu_mem_w_en      = we_q;
        lsu.o_lsu_mem_ld_extend = ~uns_q;
        lsu.o_lsu_mem_r_w_size  = size_q;
        lsu.o_lsu_mem_address   = addr_q;
        lsu.o_lsu_mem_wdata     = wdata_q;
      end
      BYTE: begin
        lsu.o_lsu_mem_w_en    = we_q;
        lsu.o_lsu_mem_address = addr_q + XLEN'(k_q);
        lsu.o_lsu_mem_wdata   = {{(XLEN-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
    if (!i_lsu_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      asm_q   <= '0;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (lsu.i_lsu_valid) begin
          we_q    <= lsu.i_lsu_we;
          uns_q   <= lsu.i_lsu_unsigned;
          size_q  <= lsu.i_lsu_size;
          addr_q  <= lsu.i_lsu_addr;
          wdata_q <= lsu.i_lsu_wdata;
          asm_q   <= '0;
          k_q     <= 3'd0;
        end
        ACC: if (!we_q) rdata_q <= lsu.i_lsu_mem_rdata;
        BYTE: begin
          k_q   <= k_q + 3'd1;
          asm_q <= asm_nxt;
          if (last && !we_q) rdata_q <= extend(asm_nxt, size_q, uns_q);
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic exc_q;
  always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
    if (!i_lsu_rst_n)                          exc_q <= 1'b0;
    else if (state_q == IDLE && lsu.i_lsu_valid) exc_q <= misalign;
  end
  assign lsu.o_lsu_misalign_exc = (state_q == RESP) & exc_q;
`else
  assign lsu.o_lsu_misalign_exc = 1'b0;
`endif

  assign lsu.o_lsu_ready = (state_q == IDLE);
  assign lsu.o_lsu_done  = (state_q == RESP);
  assign lsu.o_lsu_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_core_lsu.sv
// Bench for riscv_core_lsu: request table with a scoreboard queue, plus reset-abort and
// held-valid sequences, against a 256-byte data-memory model.
module tb_riscv_core_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_core_lsu_if #(.XLEN(64)) lsu_if ();
  riscv_core_lsu #(.XLEN(64)) dut (.i_lsu_clk(clk), .i_lsu_rst_n(rst_n), .lsu(lsu_if));

  // Data memory: combinational read with optional sign extension, write on edge.
  logic [7:0]  mem [256];
  logic        mem_clr = 1'b0;
  int          wr_cnt = 0, acc_cnt = 0, mn;
  logic [63:0] mrd;

  always_comb begin
    mn  = 1 << lsu_if.o_lsu_mem_r_w_size;
    mrd = '0;
    for (int i = 0; i < 8; i++)
      if (i < mn) mrd[i*8 +: 8] = mem[8'(lsu_if.o_lsu_mem_address[7:0] + 8'(i))];
    if (lsu_if.o_lsu_mem_ld_extend && mn < 8 && mrd[mn*8-1])
      for (int i = 0; i < 8; i++)
        if (i >= mn) mrd[i*8 +: 8] = 8'hFF;
  end
  assign lsu_if.i_lsu_mem_rdata = mrd;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (lsu_if.o_lsu_mem_w_en) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << lsu_if.o_lsu_mem_r_w_size))
          mem[8'(lsu_if.o_lsu_mem_address[7:0] + 8'(i))] <= lsu_if.o_lsu_mem_wdata[i*8 +: 8];
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk)
    if (rst_n && lsu_if.i_lsu_valid && lsu_if.o_lsu_ready) acc_cnt <= acc_cnt + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    int          lat;
    logic        exc;
    int          wr;
  } exp_t;

  vec_t        tbl [$];
  exp_t        sbq [$];
  int          nchk = 0, nerr = 0;
  logic [63:0] last_rd = '0;

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic u,
                              input logic [63:0] a, input logic [63:0] wd, input logic [63:0] ex);
    vec_t v;
    v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.exp = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    lsu_if.i_lsu_valid    = 1'b1;
    lsu_if.i_lsu_we       = v.we;
    lsu_if.i_lsu_size     = v.size;
    lsu_if.i_lsu_unsigned = v.uns;
    lsu_if.i_lsu_addr     = v.addr;
    lsu_if.i_lsu_wdata    = v.wdata;
  endtask

  task automatic run_req(input vec_t v, input string nm);
    exp_t e, g;
    int   n, c, wr0;
    logic mis, busy_bad;
    n   = 1 << v.size;
    mis = (v.addr[2:0] & 3'(n - 1)) != 3'd0;
    e.exc   = 1'b0;
    e.rdata = v.we ? last_rd : v.exp;
    e.lat   = mis ? n + 1 : 2;
    e.wr    = v.we ? (mis ? n : 1) : 0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    if (mis) begin e.exc = 1'b1; e.rdata = last_rd; e.lat = 1; e.wr = 0; end
`endif
    last_rd = e.rdata;
    sbq.push_back(e);
    @(negedge clk);
    chk({nm, " ready"}, {63'd0, lsu_if.o_lsu_ready}, 64'd1);
    drive(v);
    wr0 = wr_cnt;
    @(posedge clk);
    #1 lsu_if.i_lsu_valid = 1'b0;
    c = 0; busy_bad = 1'b0;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (lsu_if.o_lsu_done) break;
      if (lsu_if.o_lsu_ready) busy_bad = 1'b1;
    end
    g = sbq.pop_front();
    chk({nm, " latency"}, 64'(c), 64'(g.lat));
    chk({nm, " rdata"}, lsu_if.o_lsu_rdata, g.rdata);
    chk({nm, " exc"}, {63'd0, lsu_if.o_lsu_misalign_exc}, {63'd0, g.exc});
    chk({nm, " writes"}, 64'(wr_cnt - wr0), 64'(g.wr));
    chk({nm, " busy/resp"}, {62'd0, busy_bad, lsu_if.o_lsu_mem_w_en | lsu_if.o_lsu_ready}, 64'd0);
  endtask

  task automatic reset_clear();
    @(negedge clk);
    rst_n = 1'b0; mem_clr = 1'b1;
    @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
  endtask

  initial begin
    lsu_if.i_lsu_valid = 1'b0; lsu_if.i_lsu_we = 1'b0; lsu_if.i_lsu_size = 2'b00;
    lsu_if.i_lsu_unsigned = 1'b0; lsu_if.i_lsu_addr = '0; lsu_if.i_lsu_wdata = '0;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(1, 2, 0, 64'h8, 64'h8765_4321, 64'h0));
    tbl.push_back(mk(0, 2, 0, 64'h2, 64'h0, 64'h0));
    tbl.push_back(mk(0, 2, 0, 64'h8, 64'h0, 64'hFFFF_FFFF_8765_4321));
    tbl.push_back(mk(1, 3, 0, 64'h7, 64'h1122_3344_5566_7788, 64'h0));
    tbl.push_back(mk(0, 3, 0, 64'h8, 64'h0, 64'h0000_0000_8765_4321));
    tbl.push_back(mk(0, 1, 0, 64'h3, 64'h0, 64'h0));
`else
    tbl.push_back(mk(1, 2, 0, 64'h8, 64'h8765_4321, 64'h0));
    tbl.push_back(mk(0, 2, 0, 64'h8, 64'h0, 64'hFFFF_FFFF_8765_4321));
    tbl.push_back(mk(0, 2, 1, 64'h8, 64'h0, 64'h0000_0000_8765_4321));
    tbl.push_back(mk(1, 3, 0, 64'h7, 64'h1122_3344_5566_7788, 64'h0));
    tbl.push_back(mk(0, 3, 0, 64'h7, 64'h0, 64'h1122_3344_5566_7788));
    tbl.push_back(mk(1, 1, 0, 64'h1, 64'h8001, 64'h0));
    tbl.push_back(mk(0, 1, 0, 64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_8001));
    tbl.push_back(mk(0, 1, 1, 64'h1, 64'h0, 64'h0000_0000_0000_8001));
    tbl.push_back(mk(0, 0, 0, 64'hE, 64'h0, 64'h0000_0000_0000_0011));
    tbl.push_back(mk(1, 0, 0, 64'hF, 64'hA5, 64'h0));
    tbl.push_back(mk(0, 0, 0, 64'hF, 64'h0, 64'hFFFF_FFFF_FFFF_FFA5));
    tbl.push_back(mk(0, 0, 1, 64'hF, 64'h0, 64'h0000_0000_0000_00A5));
    tbl.push_back(mk(0, 2, 0, 64'h9, 64'h0, 64'h0000_0000_3344_5566));
    tbl.push_back(mk(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBEEF, 64'h0));
    tbl.push_back(mk(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0000_0000_0000_BEEF));
    tbl.push_back(mk(0, 0, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFBE));
    tbl.push_back(mk(0, 3, 0, 64'h0, 64'h0, 64'h8800_0000_0080_01BE));
    tbl.push_back(mk(0, 2, 0, 64'hC, 64'h0, 64'hFFFF_FFFF_A511_2233));
`endif

    // Reset state, with memory cleared while held in reset.
    mem_clr = 1'b1;
    @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk("reset ready", {63'd0, lsu_if.o_lsu_ready}, 64'd1);
    chk("reset done/exc/wen/ext", {60'd0, lsu_if.o_lsu_done, lsu_if.o_lsu_misalign_exc,
        lsu_if.o_lsu_mem_w_en, lsu_if.o_lsu_mem_ld_extend}, 64'd0);
    chk("reset rdata", lsu_if.o_lsu_rdata, 64'd0);
    chk("reset mem addr|wdata|size", lsu_if.o_lsu_mem_address | lsu_if.o_lsu_mem_wdata |
        64'(lsu_if.o_lsu_mem_r_w_size), 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_req(tbl[i], $sformatf("vec%0d", i));

    reset_clear();
`ifndef RISCV_LSU_MISALIGN_TRAP_EN
    // Reset while the third byte of a split SD is on the bus.
    @(negedge clk);
    drive(mk(1, 3, 0, 64'h7, 64'h1122_3344_5566_7788, 64'h0));
    @(posedge clk);
    #1 lsu_if.i_lsu_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort k2 addr", lsu_if.o_lsu_mem_address, 64'h9);
    chk("abort k2 wen", {63'd0, lsu_if.o_lsu_mem_w_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort wen drop", {63'd0, lsu_if.o_lsu_mem_w_en}, 64'd0);
    chk("abort ready/done", {62'd0, lsu_if.o_lsu_ready, lsu_if.o_lsu_done}, 64'd2);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready after", {63'd0, lsu_if.o_lsu_ready}, 64'd1);
    chk("abort mem 7..A", {mem[8'hA], mem[8'h9], mem[8'h8], mem[8'h7]}, 64'h0000_7788);
    chk("abort mem E", 64'(mem[8'hE]), 64'd0);
    chk("abort rdata", lsu_if.o_lsu_rdata, 64'd0);
`endif

    run_req(mk(1, 0, 0, 64'h8, 64'h77, 64'h0), "sb8");

    // Request held valid across a busy LW: second acceptance only from IDLE.
    begin
      int a0, c;
      @(negedge clk);
      a0 = acc_cnt;
      drive(mk(0, 2, 0, 64'h8, 64'h0, 64'h0));
      @(negedge clk);
      chk("hold acc1", 64'(acc_cnt - a0), 64'd1);
      chk("hold busy ready", {63'd0, lsu_if.o_lsu_ready}, 64'd0);
      @(negedge clk);
      chk("hold done1", {63'd0, lsu_if.o_lsu_done}, 64'd1);
      chk("hold rdata1", lsu_if.o_lsu_rdata, 64'h77);
      chk("hold resp acc", 64'(acc_cnt - a0), 64'd1);
      @(negedge clk);
      chk("hold idle ready", {63'd0, lsu_if.o_lsu_ready}, 64'd1);
      chk("hold idle acc", 64'(acc_cnt - a0), 64'd1);
      @(posedge clk);
      #1 lsu_if.i_lsu_valid = 1'b0;
      c = 0;
      while (c < 30) begin
        @(negedge clk);
        c++;
        if (lsu_if.o_lsu_done) break;
      end
      chk("hold acc2", 64'(acc_cnt - a0), 64'd2);
      chk("hold latency2", 64'(c), 64'd2);
      chk("hold rdata2", lsu_if.o_lsu_rdata, 64'h77);
    end

    chk("scoreboard empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", nchk, nerr);
    $fatal(1);
  end

endmodule
